// File: rtl/sync_fifo_bypass.sv
// Show-ahead synchronous FIFO with zero-latency bypass when empty and
// write-through-on-read when full; reports occupancy and sticky error flags.
module sync_fifo_bypass #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       write_en,
  input  logic [DATA_W-1:0]          write_data,
  input  logic                       read_en,
  output logic [DATA_W-1:0]          read_data,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic wr_acc, rd_acc, bypass, mem_we;

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CW'(AF_LEVEL));
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  assign wr_acc = write_en && (!full || read_en);
  assign rd_acc = read_en && (!empty || write_en);
  // Simultaneous read and write on an empty FIFO passes straight through.
  assign bypass = empty && write_en && read_en;
  assign mem_we = wr_acc && !bypass;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (!bypass) begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
    end
    if (write_en && full && !read_en)  overflow_d  = 1'b1;
    if (read_en && empty && !write_en) underflow_d = 1'b1;
  end

  always_comb begin
    read_data = '0;
    if (bypass)      read_data = write_data;
    else if (!empty) read_data = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[wr_ptr_q] <= write_data;
  end

endmodule

// File: tb/tb_sync_fifo_bypass.sv
// Directed plus randomized bench for sync_fifo_bypass, checked against a
// queue-based reference model of the acceptance rules.
module tb_sync_fifo_bypass;

  localparam int DATA_W   = 32;
  localparam int DEPTH    = 8;
  localparam int AF_LEVEL = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              write_en;
  logic [DATA_W-1:0] write_data;
  logic              read_en;
  logic [DATA_W-1:0] read_data;
  logic              full, empty, almost_full, overflow, underflow;
  logic [$clog2(DEPTH):0] count;

  int n_pass  = 0;
  int n_total = 0;

  logic [DATA_W-1:0] q [$];
  logic              m_ovf = 1'b0;
  logic              m_unf = 1'b0;

  sync_fifo_bypass #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .write_data(write_data),
    .read_en(read_en), .read_data(read_data), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: drive on the falling edge, check mid-cycle, then advance the model.
  task automatic cycle(input logic r, input logic we, input logic re, input logic [31:0] wd);
    logic [31:0] exp_rd;
    bit m_full, m_empty;
    @(negedge clk);
    rst = r; write_en = we; read_en = re; write_data = wd;
    #1;
    m_empty = (q.size() == 0);
    m_full  = (q.size() == DEPTH);
    if (!m_empty)     exp_rd = q[0];
    else if (we & re) exp_rd = wd;
    else              exp_rd = '0;
    chk("read_data",   read_data,   exp_rd);
    chk("count",       32'(count),  32'(q.size()));
    chk("empty",       32'(empty),  32'(m_empty));
    chk("full",        32'(full),   32'(m_full));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AF_LEVEL));
    chk("overflow",    32'(overflow),  32'(m_ovf));
    chk("underflow",   32'(underflow), 32'(m_unf));
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (we && m_full && !re)  m_ovf = 1'b1;
      if (re && m_empty && !we) m_unf = 1'b1;
      if (!(m_empty && we && re)) begin
        if (re && !m_empty) void'(q.pop_front());
        if (we && (!m_full || re)) q.push_back(wd);
      end
    end
  endtask

  initial begin
    rst = 1'b1; write_en = 1'b0; read_en = 1'b0; write_data = '0;
    @(posedge clk);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);

    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 32'h1000_0000 + 32'(i));
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);

    cycle(0, 1, 1, 32'hDEAD_BEEF);
    cycle(0, 0, 0, 0);

    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 32'(i));
    cycle(0, 1, 1, 32'hAAAA_5555);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 0, 32'h2000_0000 + 32'(i));
      cycle(0, 0, 1, 0);
    end
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 32'h3000_0000 + 32'(i));
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 32'h3000_0005 + 32'(i));

    cycle(0, 1, 0, 32'hBAD0_0001);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 32'h4000_0000 + 32'(i));
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      logic r, we, re;
      r  = ($urandom_range(0, 63) == 0);
      we = ($urandom_range(0, 99) < 55);
      re = ($urandom_range(0, 99) < 45);
      cycle(r, we, re, $urandom);
    end
    cycle(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sync_fifo_bypass.md
# sync_fifo_bypass

Synchronous show-ahead FIFO, 32-bit × 8 entries by default, with zero-latency bypass when empty and write-through-on-read when full. It is the storage stage whose accepted-write and accepted-read strobes feed the in-order scoreboard. Its acceptance rules are the definition the scoreboard checker uses. It also reports occupancy, an almost-full level, and sticky overflow/underflow error flags.

## Interface
- DATA_W, 32, data width in bits
- DEPTH, 8, number of entries; power of 2, ≥ 2
- AF_LEVEL, 6, almost_full asserts when count ≥ AF_LEVEL; 1 ≤ AF_LEVEL ≤ DEPTH

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- write_en  in  1  write request
- write_data  in  DATA_W  write payload
- read_en  in  1  read request
- read_data  out  DATA_W  head-of-queue data, or bypass data (see Operation)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was refused
- underflow  out  1  sticky: a read was refused

## Operation
- Acceptance:
  - wr_acc = write_en && (!full || read_en)
  - rd_acc = read_en && (!empty || write_en)
  - These exact expressions are the contract for the scoreboard.
- Storage: DEPTH × DATA_W register array, wr_ptr and rd_ptr of $clog2(DEPTH) bits. Pointers wrap naturally from DEPTH-1 to 0. Memory is not reset.
- Normal write (wr_acc, not bypass): mem[wr_ptr] ← write_data, wr_ptr+1.
- Normal read (rd_acc, not bypass): rd_ptr+1.
- Bypass case: empty && write_en && read_en.
  - read_data = write_data combinationally.
  - No memory write, pointers unchanged, count stays 0.
- Full with simultaneous read and write: full && write_en && read_en.
  - Head is read. The write lands at wr_ptr (== rd_ptr, the slot being vacated).
  - Both pointers advance. count stays DEPTH.
- count_next = count + wr_acc − rd_acc, except in the bypass case, where count stays 0.
  - The result is never below 0 or above DEPTH.
- read_data selection:
  - Bypass case: write_data.
  - Else if !empty: mem[rd_ptr].
  - Else: all zeros.
- full, empty and almost_full are decoded from registered count. They are glitch-free relative to inputs.
- overflow:
  - Sets on write_en && full && !read_en.
  - Cleared only by rst.
  - The refused write has no effect on state.
- underflow:
  - Sets on read_en && empty && !write_en.
  - Cleared only by rst.
  - The refused read does not move rd_ptr.

## Timing
- Reset, synchronous on the clk edge with rst=1:
  - count=0, wr_ptr=rd_ptr=0
  - empty=1, full=0, almost_full=0
  - overflow=0, underflow=0
  - read_data=0 (while write_en=0)
- While rst is high, writes and reads are ignored and status holds at its reset values. rst asserted mid-traffic discards all queued data on that edge.
- Show-ahead: the head word is valid on read_data whenever !empty. A read is consumed on the edge where rd_acc=1, and read_data presents the next word after that edge.
- Write-to-read latency:
  - A word written into an empty FIFO without a same-cycle read is visible on read_data the next cycle.
  - In bypass it is 0 cycles.
- Status (count, full, empty, almost_full) updates one edge after the accepted operation.
- Sticky flags assert one edge after the refused request.

## Test plan
- Reset, then 8 writes of 0x1000_0000+i with no reads:
  - count 1..8; full=1 after the 8th edge; almost_full=1 from count 6.
  - read_data=0x1000_0000 throughout.
  - Then 8 reads return 0x1000_0000..0x1000_0007 in order; empty=1 after.
- Empty with write_en=read_en=1, write_data=0xDEAD_BEEF for one cycle:
  - read_data=0xDEAD_BEEF in the same cycle.
  - count stays 0, empty stays 1, no flags set.
- Fill with 0..7, then one cycle of write_en=read_en=1 with 0xAAAA_5555:
  - count stays 8. Next 8 reads return 1..7 then 0xAAAA_5555.
- Wrap-around: 20 iterations of write-one/read-one alternating, then 5 writes.
  - Pointers wrap past 7. Reads return in write order; no corruption across the wrap.
- Error flags:
  - write_en alone while full → overflow=1 next cycle; contents unchanged.
  - read_en alone while empty → underflow=1 next cycle.
  - Both flags hold until rst. After rst: all outputs at reset values, and 3 entries written before the reset are gone.
